// File: rtl/noc_pkg.sv
// Shared NoC definitions: field widths and the flit bundle layout used by
// router ports and their capture stages.
package noc_pkg;

    // Coordinate width for the routing delta and destination fields.
    localparam int COORD_W = 4;

    // Payload width carried by every flit.
    localparam int DATA_W = 32;

    // One router flit; field order matches the router_if signal order.
    typedef struct packed {
        logic [COORD_W-1:0] s_delta_x;
        logic [COORD_W-1:0] s_delta_y;
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        logic [DATA_W-1:0]  data;
    } flit_t;

    // Total flit width.
    localparam int FLIT_W = $bits(flit_t);

    // Build a flit from its five fields in declaration order.
    function automatic flit_t make_flit(
        input logic [COORD_W-1:0] s_delta_x,
        input logic [COORD_W-1:0] s_delta_y,
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [DATA_W-1:0]  data
    );
        flit_t f;
        f.s_delta_x = s_delta_x;
        f.s_delta_y = s_delta_y;
        f.dest_x    = dest_x;
        f.dest_y    = dest_y;
        f.data      = data;
        return f;
    endfunction

endpackage

// File: rtl/router_if.sv
// Router flit bundle. The rx modport is the consuming side of a port,
// tx is the producing side. Widths come from noc_pkg so every router
// port in the hierarchy agrees on the flit layout.
interface router_if;
    import noc_pkg::*;

    logic [COORD_W-1:0] s_delta_x;
    logic [COORD_W-1:0] s_delta_y;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [DATA_W-1:0]  data;

    // Consumer side: every field is read.
    modport rx (
        input s_delta_x,
        input s_delta_y,
        input dest_x,
        input dest_y,
        input data
    );

    // Producer side: every field is driven.
    modport tx (
        output s_delta_x,
        output s_delta_y,
        output dest_x,
        output dest_y,
        output data
    );

endinterface

// File: rtl/interface_test_reg.sv
// Single-stage registered pass-through for one router flit bundle.
//
// Handshake: valid is a one-sided capture strobe with no ready. Whenever
// valid is high at a rising clk edge (and rst_n is high) the whole intf_in
// bundle is loaded into intf_out; the producer must assume the flit was
// taken on that edge. With valid low the output bundle holds. A low rst_n
// at an edge clears every field and discards any flit offered that cycle.
// The output is purely registered: intf_in never reaches intf_out
// combinationally.
module interface_test_reg
    import noc_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     valid,
    router_if.rx     intf_in,
    router_if.tx     intf_out
);

    // Capture all five fields together on valid, clear on reset, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intf_out.s_delta_x <= '0;
            intf_out.s_delta_y <= '0;
            intf_out.dest_x    <= '0;
            intf_out.dest_y    <= '0;
            intf_out.data      <= '0;
        end else if (valid) begin
            intf_out.s_delta_x <= intf_in.s_delta_x;
            intf_out.s_delta_y <= intf_in.s_delta_y;
            intf_out.dest_x    <= intf_in.dest_x;
            intf_out.dest_y    <= intf_in.dest_y;
            intf_out.data      <= intf_in.data;
        end
    end

endmodule

// File: tb/tb_interface_test_reg.sv
// Bench for interface_test_reg: directed test-plan sequences followed by
// randomized traffic, all compared against a flit-level reference model.
module tb_interface_test_reg;
    import noc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    router_if intf_in ();
    router_if intf_out ();

    interface_test_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .intf_in  (intf_in),
        .intf_out (intf_out)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    // Reference model: the flit the output register should be holding.
    flit_t exp_flit;
    // Flits the model accepted, oldest first; used to confirm the last
    // accepted flit is what the output shows after a capture.
    logic [FLIT_W-1:0] exp_q[$];

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Current contents of the output bundle as one flit.
    function automatic flit_t out_flit();
        return make_flit(intf_out.s_delta_x, intf_out.s_delta_y,
                         intf_out.dest_x, intf_out.dest_y, intf_out.data);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input flit_t f, input logic v, input logic r);
        intf_in.s_delta_x = f.s_delta_x;
        intf_in.s_delta_y = f.s_delta_y;
        intf_in.dest_x    = f.dest_x;
        intf_in.dest_y    = f.dest_y;
        intf_in.data      = f.data;
        valid             = v;
        rst_n             = r;
    endtask

    // One clock edge: the model applies the rule for what was presented,
    // then the output is sampled 1 time unit after the edge.
    task automatic tick(input string tag);
        flit_t presented;
        presented = make_flit(intf_in.s_delta_x, intf_in.s_delta_y,
                              intf_in.dest_x, intf_in.dest_y, intf_in.data);
        if (rst_n == 1'b0) begin
            exp_flit = '0;
        end else if (valid == 1'b1) begin
            exp_flit = presented;
            exp_q.push_back(presented);
        end
        @(posedge clk);
        #1;
        check_val(tag, 64'(out_flit()), 64'(exp_flit));
    endtask

    // Per-field check against explicit expected values.
    task automatic check_fields(input string tag, input logic [3:0] sx, input logic [3:0] sy,
                                input logic [3:0] dx, input logic [3:0] dy, input logic [31:0] d);
        check_val({tag, ".s_delta_x"}, 64'(intf_out.s_delta_x), 64'(sx));
        check_val({tag, ".s_delta_y"}, 64'(intf_out.s_delta_y), 64'(sy));
        check_val({tag, ".dest_x"},    64'(intf_out.dest_x),    64'(dx));
        check_val({tag, ".dest_y"},    64'(intf_out.dest_y),    64'(dy));
        check_val({tag, ".data"},      64'(intf_out.data),      64'(d));
    endtask

    function automatic flit_t rand_flit();
        return make_flit(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         32'($urandom));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        flit_t ones;
        flit_t zeros;
        flit_t stream[3];

        ones  = '1;
        zeros = '0;
        exp_flit = 'x;

        // Reset wins over valid with all-ones input.
        @(negedge clk);
        drive(ones, 1'b1, 1'b0);
        tick("reset");
        check_fields("reset", 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);

        // First edge out of reset captures.
        drive(ones, 1'b1, 1'b1);
        tick("capture");
        check_fields("capture", 4'hF, 4'hF, 4'hF, 4'hF, 32'hFFFF_FFFF);

        // Hold: inputs change between edges, valid low.
        drive(zeros, 1'b0, 1'b1);
        #2;
        check_val("between_edges", 64'(out_flit()), 64'(ones));
        tick("hold1");
        drive(ones, 1'b0, 1'b1);
        #2;
        drive(zeros, 1'b0, 1'b1);
        tick("hold2");
        check_fields("hold", 4'hF, 4'hF, 4'hF, 4'hF, 32'hFFFF_FFFF);

        // Recapture all-zeros.
        drive(zeros, 1'b1, 1'b1);
        tick("recapture");
        check_fields("recapture", 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);

        // Field independence.
        drive(make_flit(4'd1, 4'd2, 4'd3, 4'd4, 32'hA5A5_0F0F), 1'b1, 1'b1);
        tick("distinct");
        check_fields("distinct", 4'd1, 4'd2, 4'd3, 4'd4, 32'hA5A5_0F0F);

        // Streaming: three back-to-back flits, then reset with valid high.
        for (int i = 0; i < 3; i++) begin
            stream[i] = rand_flit();
            stream[i].data = stream[i].data ^ 32'(i + 1);
            drive(stream[i], 1'b1, 1'b1);
            tick("stream");
            check_val("stream_direct", 64'(out_flit()), 64'(stream[i]));
            check_val("stream_last", 64'(exp_q[$size(exp_q) - 1]), 64'(stream[i]));
        end
        drive(rand_flit() | 48'h1, 1'b1, 1'b0);
        tick("mid_reset");
        check_fields("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);

        // Reset release with valid captures on the first edge.
        stream[0] = make_flit(4'h9, 4'h6, 4'hC, 4'h3, 32'h1234_5678);
        drive(stream[0], 1'b1, 1'b1);
        tick("release");
        check_fields("release", 4'h9, 4'h6, 4'hC, 4'h3, 32'h1234_5678);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(rand_flit(),
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) >= 5));
            tick("random");
            // Input wiggle between edges must not reach the output.
            drive(rand_flit(), valid, rst_n);
            #2;
            check_val("random_between", 64'(out_flit()), 64'(exp_flit));
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
